picobello_noc_link_slice: RTL and testbench
===========================================

// Module: picobello_noc_link_slice
// PURPOSE
// - Retiming slice for one valid/ready NoC link channel between two adjacent mesh tiles.
// - Inserted between a tile router's output port and the neighbour's input port on long req/rsp/wide links.
// - Full throughput (1 flit/cycle); ready path is fully registered per stage.
// - Saturating flit and stall counters for link-utilisation profiling.
// PARAMETERS
// - DataWidth  | default 64 | flit payload width in bits (req/rsp/wide flit type width)
// - NumStages  | default 2  | number of cascaded 2-entry buffer stages; 0 = combinational passthrough
// - CntWidth   | default 32 | width of the profiling counters
// PORTS
// - clk_i        in   1          clock
// - rst_i        in   1          synchronous reset, active-high
// - clear_cnt_i  in   1          synchronous clear of both counters
// - valid_i      in   1          upstream flit valid
// - ready_o      out  1          upstream ready
// - data_i       in   DataWidth  upstream flit
// - valid_o      out  1          downstream flit valid
// - ready_i      in   1          downstream ready
// - data_o       out  DataWidth  downstream flit
// - idle_o       out  1          all stages empty
// - flit_cnt_o   out  CntWidth   flits accepted at output (valid_o & ready_i)
// - stall_cnt_o  out  CntWidth   cycles with valid_o & ~ready_i
// BEHAVIOUR
// - Reset (rst_i=1 at posedge): all stages empty; valid_o=0, ready_o=1, idle_o=1, counters=0, data_o='0.
// - Stage = 2-entry FIFO (wr/rd pointers 1 bit each, 2-bit fill count 0..2).
//   - in_ready = (fill != 2), registered: depends only on stage state, never on ready_i.
//   - out_valid = (fill != 0); out_data = entry[rd_ptr].
//   - push = in_valid & in_ready; pop = out_valid & out_ready; fill += push - pop; simultaneous push+pop at fill=2 illegal (push blocked).
//   - Simultaneous push and pop at fill=1: fill stays 1, pointers both advance; no bubble.
//   - Pointers wrap 1->0.
// - Stages cascaded: stage k out drives stage k+1 in; stage 0 in = ports *_i, last stage out = ports *_o.
// - Latency: empty slice, valid_i at cycle t -> valid_o at t+NumStages.
// - Throughput: continuous valid_i with ready_i=1 -> one flit out per cycle after fill-in.
// - Backpressure: with ready_i=0, slice absorbs exactly 2*NumStages flits, then ready_o=0.
// - Ordering: strict FIFO; data never dropped or duplicated.
// - Once valid_o=1 it holds, with data_o stable, until ready_i=1 (AXI-style rule); upstream must obey same rule.
// - NumStages=0: valid_o=valid_i, data_o=data_i, ready_o=ready_i, idle_o=1; counters still active.
// - idle_o = AND over stages of (fill==0), combinational from registers.
// - Counters: flit_cnt += (valid_o & ready_i); stall_cnt += (valid_o & ~ready_i).
//   - Both saturate at 2^CntWidth-1, no wrap.
//   - clear_cnt_i wins over increment in the same cycle (counter=0 next cycle).
//   - rst_i overrides clear_cnt_i.
// - Reset mid-operation: buffered flits discarded, state as at reset next cycle; no flit emitted in the reset cycle's successor.
// STRUCTURE
// - Sub-module picobello_noc_link_stage: single 2-entry stage (DataWidth param), instantiated NumStages times via generate.
// - Top level holds the cascade, idle reduction and the two counters.
// - picobello_pkg: LinkSliceStages default constant and a per-channel stage-count table (req/rsp/wide).
// - Flit typedefs stay in the NoC package; this block is type-agnostic (flat DataWidth vector).
// TESTING
// - Reset: assert rst_i 3 cycles with valid_i=1 -> valid_o=0, ready_o=1, idle_o=1, counters 0 throughout.
// - Latency/throughput, NumStages=2: stream 0x1..0x10 back-to-back, ready_i=1 -> first out at t+2, then 16 consecutive beats, flit_cnt=16, stall_cnt=0.
// - Backpressure, NumStages=2: ready_i=0, drive 6 flits -> 4 accepted, ready_o=0 from 5th; release -> 4 flits out in order, stall_cnt=cycles held.
// - Random valid/ready (50%/50%, 10k flits) vs. scoreboard FIFO -> zero loss/duplication/reorder; valid_o/data_o stable under stall.
// - Counters, CntWidth=4: 20 transfers -> flit_cnt saturates at 15; clear_cnt_i with concurrent transfer -> 0 next cycle.
// - NumStages=0 passthrough and mid-stream rst_i with 3 flits buffered -> idle_o=1 next cycle, none of the 3 flits appear.

Source files
------------

// File: rtl/picobello_noc_link_slice_pkg.sv
// Shared constants for the NoC link retiming slice: default depth and per-channel stage table.
package picobello_noc_link_slice_pkg;

   localparam int unsigned LinkSliceStages = 2;

   typedef enum logic [1:0] {
      ChanReq,
      ChanRsp,
      ChanWide
   } link_chan_e;

   localparam int unsigned LinkStagesReq  = 2;
   localparam int unsigned LinkStagesRsp  = 2;
   localparam int unsigned LinkStagesWide = 3;

   function automatic int unsigned link_slice_stages(input link_chan_e chan);
      int unsigned stages;
      stages = LinkSliceStages;
      unique case (chan)
         ChanReq:  stages = LinkStagesReq;
         ChanRsp:  stages = LinkStagesRsp;
         ChanWide: stages = LinkStagesWide;
         default:  stages = LinkSliceStages;
      endcase
      return stages;
   endfunction

endpackage

// File: rtl/picobello_noc_link_stage.sv
// One 2-entry valid/ready buffer stage; both handshake outputs come straight from registers.
module picobello_noc_link_stage #(
   parameter int unsigned DataWidth = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [DataWidth-1:0] in_data_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [DataWidth-1:0] out_data_o,
   output logic                 empty_o
);

   logic [DataWidth-1:0] mem_q [2];
   logic                 wr_ptr_q, rd_ptr_q;
   logic [1:0]           fill_q, fill_d;
   logic                 push, pop;

   assign in_ready_o  = (fill_q != 2'd2);
   assign out_valid_o = (fill_q != 2'd0);
   assign out_data_o  = mem_q[rd_ptr_q];
   assign empty_o     = (fill_q == 2'd0);

   assign push = in_valid_i & in_ready_o;
   assign pop  = out_valid_o & out_ready_i;

   always_comb begin
      fill_d = fill_q;
      unique case ({push, pop})
         2'b10:   fill_d = fill_q + 2'd1;
         2'b01:   fill_d = fill_q - 2'd1;
         default: fill_d = fill_q;
      endcase
   end

   // Entries are cleared on reset so the output data reads zero while empty.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         fill_q   <= 2'd0;
      end else begin
         fill_q <= fill_d;
         if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
      end
   end

endmodule

// File: rtl/picobello_noc_link_slice.sv
// Cascade of 2-entry link stages with idle detection and saturating flit/stall profiling counters.
module picobello_noc_link_slice
   import picobello_noc_link_slice_pkg::*;
#(
   parameter int unsigned DataWidth = 64,
   parameter int unsigned NumStages = LinkSliceStages,
   parameter int unsigned CntWidth  = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_cnt_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [DataWidth-1:0] data_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 idle_o,
   output logic [CntWidth-1:0]  flit_cnt_o,
   output logic [CntWidth-1:0]  stall_cnt_o
);

   if (NumStages == 0) begin : gen_bypass
      assign valid_o = valid_i;
      assign data_o  = data_i;
      assign ready_o = ready_i;
      assign idle_o  = 1'b1;
   end else begin : gen_stages
      logic [NumStages:0]   valid, ready;
      logic [DataWidth-1:0] data [NumStages+1];
      logic [NumStages-1:0] empty;

      assign valid[0]         = valid_i;
      assign data[0]          = data_i;
      assign ready_o          = ready[0];
      assign valid_o          = valid[NumStages];
      assign data_o           = data[NumStages];
      assign ready[NumStages] = ready_i;
      assign idle_o           = &empty;

      for (genvar k = 0; k < NumStages; k++) begin : gen_stage
         picobello_noc_link_stage #(
            .DataWidth (DataWidth)
         ) u_stage (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .in_valid_i  (valid[k]),
            .in_ready_o  (ready[k]),
            .in_data_i   (data[k]),
            .out_valid_o (valid[k+1]),
            .out_ready_i (ready[k+1]),
            .out_data_o  (data[k+1]),
            .empty_o     (empty[k])
         );
      end
   end

   logic [CntWidth-1:0] flit_cnt_q, flit_cnt_d;
   logic [CntWidth-1:0] stall_cnt_q, stall_cnt_d;
   logic                fire, stall;

   assign fire  = valid_o & ready_i;
   assign stall = valid_o & ~ready_i;

   // Clear takes priority over a same-cycle increment; both counters stick at all-ones.
   always_comb begin
      flit_cnt_d  = flit_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (clear_cnt_i) begin
         flit_cnt_d  = '0;
         stall_cnt_d = '0;
      end else begin
         if (fire && (flit_cnt_q != '1)) begin
            flit_cnt_d = flit_cnt_q + CntWidth'(1);
         end
         if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CntWidth'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         flit_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         flit_cnt_q  <= flit_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign flit_cnt_o  = flit_cnt_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_picobello_noc_link_slice.sv
// Directed and random checks of the link slice against a flit queue and counter model.
module tb_picobello_noc_link_slice;

   localparam int unsigned DW = 64;
   localparam int unsigned NumRand = 10000;

   logic          clk = 1'b0;
   logic          rst, clear_cnt, valid_i, ready_i;
   logic [DW-1:0] data_i;

   logic          a_ready_o, a_valid_o, a_idle_o;
   logic [DW-1:0] a_data_o;
   logic [31:0]   a_flit_cnt_o, a_stall_cnt_o;

   logic          b_ready_o, b_valid_o, b_idle_o;
   logic [DW-1:0] b_data_o;
   logic [3:0]    b_flit_cnt_o, b_stall_cnt_o;

   logic          c_ready_o, c_valid_o, c_idle_o;
   logic [DW-1:0] c_data_o;
   logic [31:0]   c_flit_cnt_o, c_stall_cnt_o;

   always #5 clk = ~clk;

   picobello_noc_link_slice #(.DataWidth(DW), .NumStages(2), .CntWidth(32)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .clear_cnt_i(clear_cnt), .valid_i(valid_i), .ready_o(a_ready_o),
      .data_i(data_i), .valid_o(a_valid_o), .ready_i(ready_i), .data_o(a_data_o),
      .idle_o(a_idle_o), .flit_cnt_o(a_flit_cnt_o), .stall_cnt_o(a_stall_cnt_o)
   );

   picobello_noc_link_slice #(.DataWidth(DW), .NumStages(2), .CntWidth(4)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .clear_cnt_i(clear_cnt), .valid_i(valid_i), .ready_o(b_ready_o),
      .data_i(data_i), .valid_o(b_valid_o), .ready_i(ready_i), .data_o(b_data_o),
      .idle_o(b_idle_o), .flit_cnt_o(b_flit_cnt_o), .stall_cnt_o(b_stall_cnt_o)
   );

   picobello_noc_link_slice #(.DataWidth(DW), .NumStages(0), .CntWidth(32)) u_dut_c (
      .clk_i(clk), .rst_i(rst), .clear_cnt_i(clear_cnt), .valid_i(valid_i), .ready_o(c_ready_o),
      .data_i(data_i), .valid_o(c_valid_o), .ready_i(ready_i), .data_o(c_data_o),
      .idle_o(c_idle_o), .flit_cnt_o(c_flit_cnt_o), .stall_cnt_o(c_stall_cnt_o)
   );

   int unsigned   checks = 0;
   int unsigned   errors = 0;
   logic [DW-1:0] q[$];
   int unsigned   n_out = 0;
   int unsigned   exp_flit_a = 0, exp_stall_a = 0, exp_flit_b = 0, exp_stall_b = 0;
   int unsigned   exp_flit_c = 0, exp_stall_c = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample at negedge, update the model for the coming posedge, return at posedge+1.
   task automatic mon();
      logic [DW-1:0] front;
      @(negedge clk);
      chk("c_valid", c_valid_o, valid_i);
      chk("c_data", c_data_o, data_i);
      chk("c_ready", c_ready_o, ready_i);
      chk("c_idle", c_idle_o, 1);
      chk("a_flit_cnt", a_flit_cnt_o, exp_flit_a);
      chk("a_stall_cnt", a_stall_cnt_o, exp_stall_a);
      chk("b_flit_cnt", b_flit_cnt_o, exp_flit_b);
      chk("b_stall_cnt", b_stall_cnt_o, exp_stall_b);
      chk("c_flit_cnt", c_flit_cnt_o, exp_flit_c);
      chk("c_stall_cnt", c_stall_cnt_o, exp_stall_c);
      chk("a_idle", a_idle_o, q.size() == 0);
      if (prev_stall && !rst) begin
         chk("hold_valid", a_valid_o, 1);
         chk("hold_data", a_data_o, prev_data);
      end
      if (rst) begin
         q.delete();
         exp_flit_a = 0; exp_stall_a = 0; exp_flit_b = 0; exp_stall_b = 0;
         exp_flit_c = 0; exp_stall_c = 0;
      end else begin
         if (a_valid_o && ready_i) begin
            if (q.size() != 0) begin
               front = q.pop_front();
               chk("out_data", a_data_o, front);
            end else begin
               chk("out_spurious", a_valid_o, 0);
            end
            n_out++;
         end
         if (valid_i && a_ready_o) q.push_back(data_i);
         if (clear_cnt) begin
            exp_flit_a = 0; exp_stall_a = 0; exp_flit_b = 0; exp_stall_b = 0;
            exp_flit_c = 0; exp_stall_c = 0;
         end else begin
            if (a_valid_o && ready_i) begin
               exp_flit_a++;
               if (exp_flit_b != 15) exp_flit_b++;
            end
            if (a_valid_o && !ready_i) begin
               exp_stall_a++;
               if (exp_stall_b != 15) exp_stall_b++;
            end
            if (valid_i && ready_i) exp_flit_c++;
            if (valid_i && !ready_i) exp_stall_c++;
         end
      end
      prev_stall = !rst && a_valid_o && !ready_i;
      prev_data  = a_data_o;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int unsigned idx;
      int unsigned sent;
      int unsigned out_base;
      logic        acc;
      logic        done;

      rst = 1'b1; clear_cnt = 1'b0; valid_i = 1'b1; ready_i = 1'b1; data_i = 64'hdead_beef;
      @(posedge clk);
      #1;
      // Reset held with valid_i asserted.
      repeat (3) begin
         chk("rst_valid", a_valid_o, 0);
         chk("rst_ready", a_ready_o, 1);
         chk("rst_data", a_data_o, 0);
         mon();
      end

      // Back-to-back stream 1..16: first beat two cycles later, then 16 consecutive beats.
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         valid_i = (c < 16);
         data_i  = (c < 16) ? 64'(c + 1) : 64'h0;
         chk("lat_valid", a_valid_o, (c >= 2) && (c < 18));
         if (c >= 2 && c < 18) chk("lat_data", a_data_o, 64'(c - 1));
         chk("stream_ready", a_ready_o, 1);
         mon();
      end
      chk("stream_flit", a_flit_cnt_o, 16);
      chk("stream_stall", a_stall_cnt_o, 0);
      chk("sat_flit", b_flit_cnt_o, 15);
      chk("stream_idle", a_idle_o, 1);

      // Clear coincident with an output transfer.
      valid_i = 1'b1; data_i = 64'haa;
      mon();
      valid_i = 1'b0;
      mon();
      clear_cnt = 1'b1;
      chk("clr_valid", a_valid_o, 1);
      chk("clr_data", a_data_o, 64'haa);
      mon();
      clear_cnt = 1'b0;
      chk("clr_flit_a", a_flit_cnt_o, 0);
      chk("clr_flit_b", b_flit_cnt_o, 0);
      mon();

      // Backpressure: offer 6 flits for 8 cycles with ready_i low.
      ready_i = 1'b0;
      idx = 0;
      for (int c = 0; c < 8; c++) begin
         valid_i = 1'b1;
         data_i  = 64'h21 + 64'(idx);
         chk("bp_ready", a_ready_o, c < 4);
         acc = a_ready_o;
         mon();
         if (acc) idx++;
      end
      ready_i = 1'b1;
      chk("bp_stall", a_stall_cnt_o, 6);
      chk("bp_accepted", 64'(idx), 4);
      for (int c = 0; c < 20; c++) begin
         valid_i = (idx < 6);
         data_i  = 64'h21 + 64'(idx);
         acc     = valid_i && a_ready_o;
         mon();
         if (acc) idx++;
      end
      valid_i = 1'b0;
      chk("bp_flit", a_flit_cnt_o, 6);
      chk("bp_idle", a_idle_o, 1);

      // Random valid/ready, upstream holds valid and data until accepted.
      clear_cnt = 1'b1;
      mon();
      clear_cnt = 1'b0;
      out_base = n_out;
      sent = 0;
      acc = 1'b0;
      done = 1'b0;
      for (int cyc = 0; cyc < 80000; cyc++) begin
         if (sent == NumRand && q.size() == 0 && !valid_i) begin
            done = 1'b1;
            break;
         end
         if (!valid_i || acc) begin
            if (sent < NumRand && $urandom_range(1) == 1) begin
               valid_i = 1'b1;
               data_i  = {$urandom, $urandom};
            end else begin
               valid_i = 1'b0;
            end
         end
         ready_i = ($urandom_range(1) == 1);
         acc = valid_i && a_ready_o;
         mon();
         if (acc) sent++;
      end
      chk("rand_done", done, 1);
      chk("rand_out", 64'(n_out - out_base), NumRand);
      chk("rand_flit", a_flit_cnt_o, NumRand);

      // Mid-stream reset with three flits buffered.
      valid_i = 1'b0; ready_i = 1'b0;
      mon();
      for (int i = 0; i < 3; i++) begin
         valid_i = 1'b1;
         data_i  = 64'h51 + 64'(i);
         chk("mr_ready", a_ready_o, 1);
         mon();
      end
      valid_i = 1'b0;
      chk("mr_busy", a_idle_o, 0);
      rst = 1'b1;
      mon();
      rst = 1'b0;
      ready_i = 1'b1;
      chk("mr_idle", a_idle_o, 1);
      chk("mr_flit", a_flit_cnt_o, 0);
      repeat (5) begin
         chk("mr_valid", a_valid_o, 0);
         mon();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
